// File: rtl/mdl_pgsync.sv
// mdl_pgsync -- page-sync search controller.
//
// Sits downstream of the serial sum comparator. After a start request it
// aligns to the frame boundary (rotator slot 19), then compares frame after
// frame: slots 0..11 shift the invalid-page LSB stream into a shadow word,
// and slot 18 samples the comparator verdict. A match captures the shadow
// word and reports FOUND. A mismatch bumps the retry counter, and the search
// ends in FAIL once MAX_RETRY mismatches have been seen. State only advances
// on the active-low 2 MHz clock-enable; reset is synchronous and ignores the
// enable.
//
// Ports:
//   i_MCLK          master clock
//   i_MRST          synchronous active-high reset
//   i_CLK2M_PCEN_n  2 MHz clock-enable, active-low
//   i_ROT20_n[19:0] one-hot-low frame slot rotator
//   i_SUMEQ_n       comparator verdict (0 = equal)
//   i_INVALPG_LSB   serial invalid-page bit
//   i_SEARCH_START  start request
//   i_SEARCH_ABORT  abort request (highest priority)
//   o_SEARCH_BUSY   high in ARM and COMPARE
//   o_PGFOUND       high in FOUND
//   o_SEARCH_FAIL   high in FAIL
//   o_RETRY_CNT     mismatching frames in the current search
//   o_INVALPG       invalid-page word from the matching frame
module mdl_pgsync #(
  parameter int MAX_RETRY = 15
) (
  input  logic        i_MCLK,
  input  logic        i_MRST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic [19:0] i_ROT20_n,
  input  logic        i_SUMEQ_n,
  input  logic        i_INVALPG_LSB,
  input  logic        i_SEARCH_START,
  input  logic        i_SEARCH_ABORT,
  output logic        o_SEARCH_BUSY,
  output logic        o_PGFOUND,
  output logic        o_SEARCH_FAIL,
  output logic [3:0]  o_RETRY_CNT,
  output logic [11:0] o_INVALPG
);

  // The upper three state bits are the busy/found/fail status flags, so the
  // status outputs come straight off the state register. Bit 0 only
  // separates ARM from COMPARE.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_ARM     = 4'b1000,
    ST_COMPARE = 4'b1001,
    ST_FOUND   = 4'b0100,
    ST_FAIL    = 4'b0010
  } state_t;

  localparam logic [4:0] MAX_RETRY_W = 5'(MAX_RETRY);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  retry_cnt;
  logic [3:0]  retry_nxt;
  logic [11:0] shadow;
  logic [11:0] shadow_nxt;
  logic [11:0] invalpg;
  logic [11:0] invalpg_nxt;
  logic [4:0]  retry_inc;
  logic        en;

  // Slots 12..17 carry no work for this block.
  logic unused_slots;
  assign unused_slots = &i_ROT20_n[17:12];

  assign en = ~i_CLK2M_PCEN_n;

  // One bit wider than the counter, so the compare against MAX_RETRY
  // cannot alias on a wrap.
  assign retry_inc = {1'b0, retry_cnt} + 5'd1;

  // Next-state logic. Nothing moves without the enable. Abort overrides
  // every other request in the same enable, including a verdict.
  always_comb begin
    state_nxt   = state;
    retry_nxt   = retry_cnt;
    shadow_nxt  = shadow;
    invalpg_nxt = invalpg;
    if (en) begin
      if (i_SEARCH_ABORT) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_SEARCH_START) begin
              state_nxt = ST_ARM;
              retry_nxt = 4'd0;
            end
          end
          ST_ARM: begin
            // Slot 19 is also the slot in which the comparator clears itself.
            if (!i_ROT20_n[19]) begin
              state_nxt = ST_COMPARE;
            end
          end
          ST_COMPARE: begin
            for (int k = 0; k < 12; k++) begin
              if (!i_ROT20_n[k]) begin
                shadow_nxt[k] = i_INVALPG_LSB;
              end
            end
            if (!i_ROT20_n[18]) begin
              if (!i_SUMEQ_n) begin
                state_nxt   = ST_FOUND;
                invalpg_nxt = shadow_nxt;
              end else if (retry_inc == MAX_RETRY_W) begin
                state_nxt = ST_FAIL;
                retry_nxt = retry_inc[3:0];
              end else begin
                retry_nxt = retry_inc[3:0];
              end
            end
          end
          ST_FOUND, ST_FAIL: begin
            if (i_SEARCH_START) begin
              state_nxt = ST_ARM;
              retry_nxt = 4'd0;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  // State, counter, shadow and captured word registers.
  always_ff @(posedge i_MCLK) begin
    if (i_MRST) begin
      state     <= ST_IDLE;
      retry_cnt <= 4'd0;
      shadow    <= 12'h000;
      invalpg   <= 12'h000;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      shadow    <= shadow_nxt;
      invalpg   <= invalpg_nxt;
    end
  end

  assign o_SEARCH_BUSY = state[3];
  assign o_PGFOUND     = state[2];
  assign o_SEARCH_FAIL = state[1];
  assign o_RETRY_CNT   = retry_cnt;
  assign o_INVALPG     = invalpg;

endmodule

// File: tb/tb_mdl_pgsync.sv
// tb_mdl_pgsync -- self-checking bench for mdl_pgsync (MAX_RETRY = 4).
//
// Each search is described at frame level: how many mismatching frames come
// before the match and which 12-bit word the matching frame carries. The
// expected outcome (FOUND/FAIL, retry count, captured word) is queued just
// before the deciding verdict is driven. A monitor pops and compares
// whenever FOUND or FAIL rises. Direct checks cover reset, start-to-busy,
// enable gating, abort priority and the sticky FAIL state.
module tb_mdl_pgsync;

  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_n;
  logic [19:0] rot;
  logic        sumeq;
  logic        lsb;
  logic        start;
  logic        abort;
  logic        busy;
  logic        found;
  logic        fail;
  logic [3:0]  cnt;
  logic [11:0] invalpg;

  int checks = 0;
  int errors = 0;
  int slot   = 0;

  typedef struct {
    logic        found;
    logic        fail;
    logic [3:0]  cnt;
    logic [11:0] inval;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] model_inval = 12'h000;

  mdl_pgsync #(.MAX_RETRY(MAXR)) dut (
    .i_MCLK        (clk),
    .i_MRST        (rst),
    .i_CLK2M_PCEN_n(en_n),
    .i_ROT20_n     (rot),
    .i_SUMEQ_n     (sumeq),
    .i_INVALPG_LSB (lsb),
    .i_SEARCH_START(start),
    .i_SEARCH_ABORT(abort),
    .o_SEARCH_BUSY (busy),
    .o_PGFOUND     (found),
    .o_SEARCH_FAIL (fail),
    .o_RETRY_CNT   (cnt),
    .o_INVALPG     (invalpg)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Disabled cycles: garbage on every input, including start and abort.
  task automatic junkCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      en_n  = 1'b1;
      rot   = 20'($urandom);
      sumeq = rb();
      lsb   = rb();
      start = rb();
      abort = rb();
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  // One enabled cycle at the current slot, sometimes preceded by a
  // disabled cycle. Returns #1 after the enable edge.
  task automatic applyStimulus(input logic st, input logic ab,
                               input logic sq, input logic lb);
    if ($urandom_range(0, 3) == 0) junkCycles(1);
    @(negedge clk);
    en_n  = 1'b0;
    rot   = ~(20'd1 << slot);
    start = st;
    abort = ab;
    sumeq = sq;
    lsb   = lb;
    @(posedge clk);
    #1;
    en_n  = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rot   = 20'($urandom);
    slot  = (slot + 1) % 20;
  endtask

  // Scoreboard monitor: a rising FOUND or FAIL must match the oldest
  // queued expectation.
  logic prev_found = 1'b0;
  logic prev_fail  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_found = 1'b0;
      prev_fail  = 1'b0;
    end else begin
      if ((found && !prev_found) || (fail && !prev_fail)) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_status", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_found", found, e.found);
          checkOutput("sb_fail", fail, e.fail);
          checkOutput("sb_retry_cnt", cnt, e.cnt);
          checkOutput("sb_invalpg", invalpg, e.inval);
        end
      end
      prev_found = found;
      prev_fail  = fail;
    end
  end

  // One complete search: n_mis mismatching frames, then a match carrying
  // word (or FAIL if n_mis reaches MAXR). late starts on slot 19, abort_v
  // aborts on the matching verdict, gate stalls the enable mid-frame.
  task automatic runSearch(input int n_mis, input logic [11:0] word,
                           input bit late, input bit abort_v, input bit gate);
    int          frames;
    int          s;
    logic        mis;
    logic        last;
    logic [11:0] fw;
    exp_t        e;
    if (late) while (slot != 19) applyStimulus(1'b0, 1'b0, rb(), rb());
    applyStimulus(1'b1, 1'b0, rb(), rb());
    checkOutput("busy_after_start", busy, 1);
    checkOutput("cnt_cleared", cnt, 0);
    // Alignment: ARM sees the first slot 19 strictly after the start.
    do begin
      s = slot;
      applyStimulus(rb(), 1'b0, rb(), rb());
    end while (s != 19);
    frames = (n_mis >= MAXR) ? MAXR : n_mis + 1;
    for (int f = 0; f < frames; f++) begin
      mis  = (f < n_mis);
      last = (f == frames - 1);
      fw   = mis ? 12'($urandom) : word;
      for (int k = 0; k < 19; k++) begin
        if (gate && last && k == 5) begin
          junkCycles(7);
          checkOutput("gate_busy", busy, 1);
          checkOutput("gate_found", found, 0);
          checkOutput("gate_cnt", cnt, 32'(f));
          checkOutput("gate_invalpg", invalpg, model_inval);
        end
        if (k == 18 && last && !abort_v) begin
          if (mis) begin
            e = '{found: 1'b0, fail: 1'b1, cnt: 4'(MAXR), inval: model_inval};
          end else begin
            e = '{found: 1'b1, fail: 1'b0, cnt: 4'(n_mis), inval: word};
            model_inval = word;
          end
          sb_q.push_back(e);
        end
        applyStimulus(last ? 1'b0 : rb(), (k == 18) ? abort_v : 1'b0,
                      (k == 18) ? mis : rb(), (k < 12) ? fw[k] : rb());
      end
      if (!last) begin
        checkOutput("frame_cnt", cnt, 32'(f + 1));
        checkOutput("frame_busy", busy, 1);
        applyStimulus(rb(), 1'b0, rb(), rb());
      end
    end
    if (abort_v) begin
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_found", found, 0);
      checkOutput("abort_fail", fail, 0);
      checkOutput("abort_invalpg", invalpg, model_inval);
      checkOutput("abort_cnt", cnt, 32'(n_mis));
    end
  endtask

  initial begin
    rst   = 1'b1;
    en_n  = 1'b1;
    rot   = 20'hFFFFF;
    sumeq = 1'b1;
    lsb   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_found", found, 0);
    checkOutput("reset_fail", fail, 0);
    checkOutput("reset_cnt", cnt, 0);
    checkOutput("reset_invalpg", invalpg, 0);

    $display("[TB] first-frame match");
    runSearch(0, 12'hA5C, 1'b0, 1'b0, 1'b0);
    $display("[TB] match after three retries");
    runSearch(3, 12'h3C7, 1'b0, 1'b0, 1'b0);
    $display("[TB] exhausted search");
    runSearch(4, 12'h111, 1'b0, 1'b0, 1'b0);
    repeat (40) applyStimulus(1'b0, 1'b0, rb(), rb());
    checkOutput("sticky_fail", fail, 1);
    checkOutput("sticky_busy", busy, 0);
    checkOutput("sticky_found", found, 0);
    checkOutput("sticky_cnt", cnt, MAXR);
    $display("[TB] abort on verdict");
    runSearch(0, 12'hFFF, 1'b0, 1'b1, 1'b0);
    $display("[TB] enable gating");
    runSearch(2, 12'h5A6, 1'b0, 1'b0, 1'b1);
    $display("[TB] late start on slot 19");
    runSearch(1, 12'h9C3, 1'b1, 1'b0, 1'b0);

    $display("[TB] randomized searches");
    for (int i = 0; i < 6; i++) begin
      runSearch($urandom_range(0, 5), 12'($urandom), 1'($urandom),
                1'b0, 1'($urandom));
      repeat ($urandom_range(0, 25)) applyStimulus(1'b0, 1'b0, rb(), rb());
    end

    $display("[TB] reset mid-compare");
    applyStimulus(1'b1, 1'b0, rb(), rb());
    repeat (30) applyStimulus(1'b0, 1'b0, rb(), rb());
    @(negedge clk);
    rst  = 1'b1;
    en_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_inval = 12'h000;
    applyStimulus(1'b0, 1'b0, rb(), rb());
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_found", found, 0);
    checkOutput("midreset_fail", fail, 0);
    checkOutput("midreset_cnt", cnt, 0);
    checkOutput("midreset_invalpg", invalpg, 0);
    runSearch(1, 12'h2B4, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdl_pgsync.md
# mdl_pgsync

Page-sync search controller that sits directly downstream of the serial sum comparator in the bubble-memory datapath. It consumes the per-frame comparator verdict (`SUMEQ_n`) and the serial invalid-page LSB stream, and runs a bounded search for a matching page frame. It reports found/fail status, the retry count and the 12-bit invalid-page word captured on the matching frame. Frame timing comes from the shared 20-slot one-hot-low rotator, and all state advances on the 2 MHz clock-enable.

## Interface
Parameters:
- `MAX_RETRY`, default 15: number of mismatching frames tolerated before failure; range 1..15.

Ports:
- `i_MCLK`  in  1  master clock; the only clock.
- `i_MRST`  in  1  reset; synchronous, active-high; sampled on `i_MCLK` regardless of clock-enable.
- `i_CLK2M_PCEN_n`  in  1  2 MHz clock-enable, active-low; all state updates only when 0.
- `i_ROT20_n`  in  20  one-hot-low frame slot rotator; exactly one bit low per enable.
- `i_SUMEQ_n`  in  1  comparator output; 0 = sum equal, 1 = mismatch latched this frame.
- `i_INVALPG_LSB`  in  1  serial invalid-page bit from the constant shift register.
- `i_SEARCH_START`  in  1  start request, level-sampled on an enable.
- `i_SEARCH_ABORT`  in  1  abort request; returns the block to IDLE.
- `o_SEARCH_BUSY`  out  1  high in ARM and COMPARE.
- `o_PGFOUND`  out  1  high in FOUND.
- `o_SEARCH_FAIL`  out  1  high in FAIL.
- `o_RETRY_CNT`  out  4  mismatching frames counted in the current search.
- `o_INVALPG`  out  12  invalid-page word captured from the matching frame.

## Operation
- State machine: IDLE, ARM, COMPARE, FOUND, FAIL. State is encoded so it is readable as the three status outputs.
- **IDLE**
  - `i_SEARCH_START`=1 goes to ARM.
  - On that transition, `o_RETRY_CNT` is cleared to 0.
- **ARM**
  - Waits for frame alignment.
  - On the enable with `i_ROT20_n[19]`=0, goes to COMPARE. This is the same slot in which the comparator clears itself.
- **COMPARE**
  - Slots 0..11 (`i_ROT20_n[k]`=0): shadow register bit k <= `i_INVALPG_LSB`. The word is assembled LSB first.
  - On the enable with `i_ROT20_n[18]`=0, `i_SUMEQ_n` is sampled as the frame verdict.
  - Verdict 0: go to FOUND; `o_INVALPG` <= the shadow register, with the bit from slot 11 included.
  - Verdict 1 with `o_RETRY_CNT`+1 == `MAX_RETRY`: go to FAIL; the counter is also incremented.
  - Verdict 1 otherwise: increment `o_RETRY_CNT` and stay in COMPARE. The next frame starts at the following slot 19/0 without re-arming.
- **FOUND / FAIL**
  - Sticky.
  - `i_SEARCH_START`=1 goes to ARM, clears the counter and keeps `o_INVALPG`.
- **Abort**
  - `i_SEARCH_ABORT`=1 from any state goes to IDLE on that enable.
  - Counter and `o_INVALPG` hold their values.
  - Abort takes priority over start and over a verdict in the same enable.
- **Counter arithmetic**
  - `o_RETRY_CNT` is 4-bit unsigned.
  - It never exceeds `MAX_RETRY` and never wraps.

## Timing
- **Reset** (`i_MRST`=1 at a `i_MCLK` edge, enable ignored):
  - state = IDLE.
  - `o_SEARCH_BUSY` = 0, `o_PGFOUND` = 0, `o_SEARCH_FAIL` = 0.
  - `o_RETRY_CNT` = 0, `o_INVALPG` = 12'h000, shadow register = 0.
  - Reset mid-search discards the search entirely.
- **Registered outputs:** all outputs are registered and change on the `i_MCLK` edge of the qualifying enable.
- **Start to busy:** `o_SEARCH_BUSY` rises one enable after start is sampled.
- **Verdict to status:** `o_PGFOUND` / `o_SEARCH_FAIL` rise on the enable following the slot-18 sample, i.e. at the slot-19 enable.
- **Start on slot 19:** if start is sampled on the slot-19 enable, ARM is entered at slot 0 and waits a full frame. Alignment is never taken from the same enable.
- **Clock-enable gating:** with `i_CLK2M_PCEN_n`=1, no state, counter or shadow bit changes, even if the rotator input toggles.
- **Start while busy:** ignored in ARM and COMPARE.
- **Worst-case search length:** 1 align frame plus `MAX_RETRY` compare frames = (`MAX_RETRY`+1)×20 enables.

## Test plan
- **Reset:** assert `i_MRST` for 3 `i_MCLK` cycles during COMPARE -> all outputs 0 and IDLE on the first enable after release.
- **First-frame match:** start, feed `i_SUMEQ_n`=0 at slot 18 and `i_INVALPG_LSB` pattern 12'hA5C (bit k at slot k) -> `o_PGFOUND`=1 at slot 19, `o_INVALPG`=12'hA5C, `o_RETRY_CNT`=0.
- **Match after retries:** three mismatch frames, then a match -> `o_RETRY_CNT`=3, FOUND, no re-arm gap between frames (frame 2 verdict exactly 20 enables after frame 1).
- **Exhausted search:** `MAX_RETRY`=4, all mismatch -> `o_SEARCH_FAIL`=1 after the 4th verdict, `o_RETRY_CNT`=4, BUSY 0; a further 40 enables change nothing.
- **Abort priority:** assert abort and a matching verdict on the same slot-18 enable -> IDLE, `o_PGFOUND` stays 0, `o_INVALPG` unchanged from its prior value.
- **Enable gating and late start:** hold `i_CLK2M_PCEN_n`=1 for 7 `i_MCLK` cycles mid-COMPARE -> no change. Start sampled at slot 19 -> COMPARE entered one full frame later.
